// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage buffers: control bundle layout,
// ALU opcodes and the bubble (NOP) control word.
package pipe_pkg;

  localparam int CTRL_W     = 13;
  localparam int DATA_W     = 96;

  localparam int W_RF_LSB   = 0;
  localparam int W_RF_W     = 3;
  localparam int W_RB_LSB   = 3;
  localparam int S_MXRB_LSB = 4;
  localparam int S_MXRB_W   = 2;
  localparam int W_DM_LSB   = 6;
  localparam int OP_ALU_LSB = 7;
  localparam int OP_ALU_W   = 5;
  localparam int S_MXSE_LSB = 12;

  typedef enum logic [OP_ALU_W-1:0] {
    ALU_ADD   = 5'b00000,
    ALU_SUB   = 5'b00001,
    ALU_AND   = 5'b00010,
    ALU_OR    = 5'b00011,
    ALU_XOR   = 5'b00100,
    ALU_SLT   = 5'b00101,
    ALU_PASSA = 5'b10010,
    ALU_PASSB = 5'b10011
  } op_alu_e;

  typedef struct packed {
    logic                s_mxse;
    op_alu_e             op_alu;
    logic                w_dm;
    logic [S_MXRB_W-1:0] s_mxrb;
    logic                w_rb;
    logic [W_RF_W-1:0]   w_rf;
  } ctrl_t;

  // Bubble: sign-extend select, ALU passes B, no architectural writes.
  localparam logic [CTRL_W-1:0] CTRL_NOP_DEF =
    {1'b1, ALU_PASSB, 1'b0, 2'b00, 1'b0, 3'b000};

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Ready/valid handshake bundle between two pipeline stages.
interface pipe_stage_buf_if #(
  parameter int CTRL_W = 13,
  parameter int DATA_W = 96
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_slot.sv
// One buffer entry: valid bit plus control/data payload, with load and clear.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 13,
  parameter int DATA_W = 96
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clear wins over load so a flush can never be overridden by a capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages with flush, NOP insertion on
// bubbles and a saturating back-pressure counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 13,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEF),
  parameter int                CNT_W    = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  pipe_stage_buf_if.slave      bus,
  output logic [CNT_W-1:0]     stall_cnt
);
  logic              w_main_v, w_skid_v;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_data_d;
  logic              w_in_xfer, w_out_xfer;
  logic              w_main_load, w_main_clr, w_skid_load, w_skid_clr;
  logic [CNT_W-1:0]  r_stall_cnt;

  // in_ready is derived only from the skid valid register.
  assign w_in_xfer  = bus.in_valid & ~w_skid_v;
  assign w_out_xfer = w_main_v & bus.out_ready;

  // When the skid holds an entry it always refills main first, keeping order.
  assign w_main_load   = ~FLUSH & (w_skid_v ? w_out_xfer
                                            : (w_in_xfer & (~w_main_v | w_out_xfer)));
  assign w_main_clr    = FLUSH | (w_out_xfer & ~w_skid_v & ~w_in_xfer);
  assign w_skid_load   = ~FLUSH & w_in_xfer & w_main_v & ~w_out_xfer;
  assign w_skid_clr    = FLUSH | (w_skid_v & w_out_xfer);
  assign w_main_ctrl_d = w_skid_v ? w_skid_ctrl : bus.in_ctrl;
  assign w_main_data_d = w_skid_v ? w_skid_data : bus.in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_clr   (w_main_clr),
    .i_load  (w_main_load),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_valid (w_main_v),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_clr   (w_skid_clr),
    .i_load  (w_skid_load),
    .i_ctrl  (bus.in_ctrl),
    .i_data  (bus.in_data),
    .o_valid (w_skid_v),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET)
      r_stall_cnt <= '0;
    else if (w_main_v && !bus.out_ready && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign bus.in_ready  = ~w_skid_v;
  assign bus.out_valid = w_main_v;
  assign bus.out_ctrl  = w_main_v ? w_main_ctrl : CTRL_NOP;
  assign bus.out_data  = w_main_v ? w_main_data : '0;
  assign stall_cnt     = r_stall_cnt;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: stimulus queues accepted entries,
// a negedge monitor checks every output transfer against the queue.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int DW    = 96;
  localparam int CW    = 13;
  localparam int CNT_W = 2;
  localparam logic [CW-1:0] NOP = 13'h1980;

  logic             CLK = 1'b0;
  logic             RESET, FLUSH;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) bus();

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output transfer is decided at the next posedge; sample mid-cycle.
  always @(negedge CLK) begin
    if (!RESET && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_out: got ctrl %0h data %0h with nothing expected",
                 bus.out_ctrl, bus.out_data);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("sb_ctrl", 128'(bus.out_ctrl), 128'(e.c));
        chk("sb_data", 128'(bus.out_data), 128'(e.d));
      end
    end
  end

  // Advance one clock; an accepted input becomes an expected output,
  // a flush or reset discards everything still held.
  task automatic cyc();
    logic drop;
    drop = FLUSH || RESET;
    if (bus.in_valid && bus.in_ready && !drop)
      exp_q.push_back({bus.in_ctrl, bus.in_data});
    @(posedge CLK);
    #1;
    if (drop) exp_q.delete();
  endtask

  task automatic put(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "_ctrl"},  128'(bus.out_ctrl),  128'(NOP));
    chk({tag, "_data"},  128'(bus.out_data),  128'(0));
    chk({tag, "_ready"}, 128'(bus.in_ready),  128'(1));
  endtask

  initial begin
    int exp_cnt[6];
    exp_cnt = '{1, 2, 3, 3, 3, 3};

    RESET = 1'b1; FLUSH = 1'b0; bus.out_ready = 1'b0;
    put(1'b0, '0, '0);
    #1;
    cyc(); cyc();
    RESET = 1'b0;
    chk_idle("reset");
    chk("reset_stall", 128'(stall_cnt), 128'(0));

    // Streaming: one entry per cycle, visible one cycle after accept.
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      put(1'b1, 13'h0040 | 13'(k), DW'(k));
      cyc();
      chk("stream_valid", 128'(bus.out_valid), 128'(1));
      chk("stream_data",  128'(bus.out_data),  128'(k));
      chk("stream_ready", 128'(bus.in_ready),  128'(1));
    end
    put(1'b0, '0, '0);
    cyc();
    chk_idle("stream_end");

    // Back-pressure: A in main, B absorbed into skid, C held upstream.
    put(1'b1, 13'h0A01, 96'hA);
    cyc();
    bus.out_ready = 1'b0;
    put(1'b1, 13'h0B02, 96'hB);
    cyc();
    chk("bp_ready_full", 128'(bus.in_ready), 128'(0));
    chk("bp_main_a",     128'(bus.out_data), 128'(96'hA));
    chk("bp_stall1",     128'(stall_cnt),    128'(1));
    put(1'b1, 13'h0C03, 96'hC);
    cyc();
    chk("bp_ready_hold", 128'(bus.in_ready), 128'(0));
    chk("bp_stall2",     128'(stall_cnt),    128'(2));
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_main_b",   128'(bus.out_data), 128'(96'hB));
    chk("bp_ready_re", 128'(bus.in_ready), 128'(1));
    cyc();
    chk("bp_main_c",   128'(bus.out_data), 128'(96'hC));
    put(1'b0, '0, '0);
    cyc();
    chk("bp_drained", 128'(exp_q.size()), 128'(0));
    chk("bp_stall_keep", 128'(stall_cnt), 128'(2));

    // Flush while FULL with a presented input.
    bus.out_ready = 1'b0;
    put(1'b1, 13'h0D04, 96'hD0);
    cyc();
    put(1'b1, 13'h0D05, 96'hD1);
    cyc();
    chk("fl_full", 128'(bus.in_ready), 128'(0));
    put(1'b1, 13'h0E06, 96'hEE);
    FLUSH = 1'b1;
    cyc();
    FLUSH = 1'b0;
    chk_idle("flush_full");
    // Flush while ONE with an input that would otherwise be accepted.
    put(1'b1, 13'h0F07, 96'hF0);
    cyc();
    put(1'b1, 13'h0F08, 96'hF1);
    FLUSH = 1'b1;
    cyc();
    FLUSH = 1'b0;
    put(1'b0, '0, '0);
    chk_idle("flush_one");
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    chk("flush_nothing_out", 128'(bus.out_valid), 128'(0));

    // Stall counter saturation.
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    chk("cnt_reset", 128'(stall_cnt), 128'(0));
    put(1'b1, 13'h0111, 96'h5);
    cyc();
    bus.out_ready = 1'b0;
    put(1'b0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("cnt_sat%0d", i), 128'(stall_cnt), 128'(exp_cnt[i]));
    end

    // Reset while FULL discards both entries.
    put(1'b1, 13'h0222, 96'h6);
    cyc();
    chk("rst_full", 128'(bus.in_ready), 128'(0));
    put(1'b1, 13'h0333, 96'h7);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    put(1'b0, '0, '0);
    chk_idle("rst_mid");
    chk("rst_mid_stall", 128'(stall_cnt), 128'(0));
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    chk("final_drain", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage buffer for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). Replaces ENABLE-gated stage registers with a two-entry ready/valid skid buffer. Carries a control bundle and a data bundle, and inserts a NOP control word on bubbles and flushes. Adds a saturating back-pressure counter for hazard profiling.

## Interface
Parameters:
- DATA_W, 96: data bundle width (PC, PRA, PRB by default).
- CTRL_W, 13: control bundle width, packed {S_MXSE, OP_ALU[4:0], W_DM, S_MXRB[1:0], W_RB, W_RF[2:0]}.
- CTRL_NOP, 13'h1980: control value presented when no valid entry is held (S_MXSE=1, OP_ALU=passb, all writes 0).
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  buffer can accept; registered, not combinationally dependent on out_ready.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- FLUSH  in  1  discard all held entries (branch taken, exception).
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  main control, or CTRL_NOP when out_valid=0.
- out_data  out  DATA_W  main data, or 0 when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: a main register (drives outputs) and a skid register, each with a valid bit.
- A transfer occurs on the input side when in_valid and in_ready are both 1. A transfer occurs on the output side when out_valid and out_ready are both 1.
- Occupancy states:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- EMPTY: an input transfer loads main → ONE.
- ONE, three cases:
  - Input and output transfer together: main is reloaded from the input, stays ONE.
  - Output transfer only → EMPTY.
  - Input transfer without an output transfer: the input goes into skid → FULL.
- FULL: in_ready=0. An output transfer moves skid into main → ONE.
- in_ready equals NOT skid-valid, registered.
- Invalid main forces out_ctrl=CTRL_NOP and out_data=0.
- FLUSH (priority over everything):
  - Clears both valid bits → EMPTY next cycle.
  - Any input presented in the same cycle is dropped.
  - An output transfer in the same cycle still counts as consumed downstream.
- stall_cnt increments when out_valid=1 and out_ready=0, saturates at 2^CNT_W−1, and is cleared only by RESET.

## Timing
- Reset values: out_valid=0, in_ready=1, out_ctrl=CTRL_NOP, out_data=0, stall_cnt=0, skid invalid.
- RESET mid-operation discards both entries in that edge.
- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. one cycle.
- Throughput: one entry per cycle while out_ready is held at 1.
- out_ready dropping while ONE: one more input is absorbed into skid, then in_ready=0 from the next cycle.
- FLUSH with RESET together: reset behaviour applies.
- in_ctrl and in_data are ignored whenever in_valid=0 or in_ready=0.

## Structure
- Shared package pipe_pkg holds:
  - control field widths and offsets;
  - the CTRL_NOP constant;
  - OP_ALU encodings, including passb=5'b10011.
- One natural sub-module, pipe_slot: a single valid+ctrl+data register with load/clear. It is instantiated twice, as main and skid.
- The counter is inline.

## Test plan
- Reset → out_valid=0, out_ctrl=13'h1980, out_data=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, in_valid=1 for 4 cycles with data 1,2,3,4 → out_data=1,2,3,4 on consecutive cycles, one cycle after each accept, in_ready stays 1.
- Back-pressure:
  - Stimulus: accept A, drop out_ready, present B and C.
  - Required: B goes to skid; in_ready=0 the next cycle; C is held upstream; stall_cnt increments each stalled cycle.
  - Then raise out_ready → A, B, C are delivered in order.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, out_ctrl=13'h1980, in_ready=1, and the presented input is never output.
- Stall counter with CNT_W=2: stall 6 cycles → stall_cnt reads 1,2,3,3,3,3.
- RESET asserted while FULL → both entries lost, and outputs return to reset values after the edge.
